// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: per-channel synchroniser, shared sample-tick divider, stable counters.
// Optional rise/fall edge pulses are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_bank #(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] d,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [DW-1:0]       r_div;
    logic [DW-1:0]       w_div_nxt;
    logic                r_run;
    logic                r_tick;
    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] r_q;
    logic [CW-1:0]       r_cnt  [CHANNELS];
    logic [CHANNELS-1:0] w_acc;

    // The first edge after reset only arms the divider, so tick lands exactly TICK_DIV edges later.
    always_comb begin
        w_div_nxt = '0;
        if (r_run && (r_div != DIV_LAST)) begin
            w_div_nxt = r_div + DW'(1);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            r_div  <= w_div_nxt;
            r_tick <= (w_div_nxt == DIV_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_acc[i] = r_tick && (w_s[i] != r_q[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_q <= (r_q & ~w_acc) | (w_s & w_acc);
            for (int i = 0; i < CHANNELS; i++) begin
                if ((w_s[i] == r_q[i]) || w_acc[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_tick) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_acc & w_s;
            r_fall <= w_acc & ~w_s;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = '0;
    assign fall = '0;
`endif

    assign q    = r_q;
    assign tick = r_tick;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (CHANNELS=4, SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3).
// Edge-pulse expectations follow whether DEBOUNCE_EDGE_EN is defined.
module tb_debounce_bank;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d;
    logic [3:0] q, rise, fall;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] rise_or   = '0;
    logic [3:0] fall_or   = '0;
    logic       both_seen = 1'b0;

    debounce_bank #(
        .CHANNELS    (4),
        .SYNC_STAGES (2),
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .tick (tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        rise_or <= rise_or | rise;
        fall_or <= fall_or | fall;
        if (|(rise & fall)) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Returns just before the edge that follows a sampled tick, so that edge is edge 1 of the next step.
    task automatic tick_align();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("tick_align", {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    task automatic watch_q(input logic [3:0] q_before, output int lat,
                           output logic [3:0] q_after, output logic [3:0] r_at,
                           output logic [3:0] f_at);
        lat     = 0;
        q_after = q_before;
        r_at    = '0;
        f_at    = '0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (q !== q_before) begin
                lat     = k;
                q_after = q;
                r_at    = rise;
                f_at    = fall;
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        int         bad;
        logic [3:0] qa, ra, fa;

        rst_n = 1'b0;
        d     = 4'h0;
        @(posedge clk);
        #1;
        check("rst_q", {28'd0, q}, 32'h0);
        check("rst_tick", {31'd0, tick}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bring all channels high, then yank reset mid-cycle
        d = 4'hF;
        watch_q(4'h0, lat, qa, ra, fa);
        check("all_up_q", {28'd0, qa}, 32'hF);
        check("all_up_rise", {28'd0, ra}, EDGE_EN ? 32'hF : 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", {28'd0, q}, 32'h0);
        check("async_rst_rise", {28'd0, rise}, 32'h0);
        check("async_rst_fall", {28'd0, fall}, 32'h0);
        check("async_rst_tick", {31'd0, tick}, 32'h0);
        d = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tick_after_edge%0d", k), {31'd0, tick}, (k == 4) ? 32'd1 : 32'd0);
        end

        // Clean press on channel 0, aligned to a tick: ticks used at edges 5, 9, 13
        tick_align();
        d = 4'h1;
        watch_q(4'h0, lat, qa, ra, fa);
        check("press_lat", lat, 32'd13);
        check("press_q", {28'd0, qa}, 32'h1);
        check("press_rise", {28'd0, ra}, EDGE_EN ? 32'h1 : 32'h0);
        check("press_fall", {28'd0, fa}, 32'h0);
        @(posedge clk);
        #1;
        check("press_rise_1cyc", {28'd0, rise}, 32'h0);

        // Bounce on channel 1 must never be accepted
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k < 40 && (k % 3) == 0) d[1] = ~d[1];
            if (k == 40) d[1] = 1'b0;
            if (q !== 4'h1 || rise !== 4'h0 || fall !== 4'h0) bad++;
        end
        check("bounce_bad_cycles", bad, 32'd0);

        // Raise the rest, then drop channels 3:2 together
        @(negedge clk);
        d = 4'hF;
        watch_q(4'h1, lat, qa, ra, fa);
        check("raise_q", {28'd0, qa}, 32'hF);
        check("raise_rise", {28'd0, ra}, EDGE_EN ? 32'hE : 32'h0);
        tick_align();
        d = 4'h3;
        watch_q(4'hF, lat, qa, ra, fa);
        check("release_lat", lat, 32'd13);
        check("release_q", {28'd0, qa}, 32'h3);
        check("release_fall", {28'd0, fa}, EDGE_EN ? 32'hC : 32'h0);
        check("release_rise", {28'd0, ra}, 32'h0);
        @(posedge clk);
        #1;
        check("release_fall_1cyc", {28'd0, fall}, 32'h0);

        // Reset after two disagreeing ticks aborts the pending acceptance
        @(negedge clk);
        d = 4'h0;
        watch_q(4'h3, lat, qa, ra, fa);
        check("clear_q", {28'd0, qa}, 32'h0);
        tick_align();
        d = 4'h1;
        for (int k = 1; k <= 10; k++) @(posedge clk);
        #1;
        check("midcount_q", {28'd0, q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        watch_q(4'h0, lat, qa, ra, fa);
        check("post_rst_lat", lat, 32'd13);
        check("post_rst_q", {28'd0, qa}, 32'h1);

        @(negedge clk);
        @(negedge clk);
        check("rise_seen", {28'd0, rise_or}, EDGE_EN ? 32'hF : 32'h0);
        check("fall_seen", {28'd0, fall_or}, EDGE_EN ? 32'hF : 32'h0);
        check("rise_fall_both", {31'd0, both_seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter CHANNELS SHALL default to 4 and set the number of independent input channels (valid range 1..32).
REQ-003 Parameter SYNC_STAGES SHALL default to 2 and set the input synchroniser depth (valid range 2..4).
REQ-004 Parameter TICK_DIV SHALL default to 1000 and set the clk cycles per sample tick (valid range 1..65535).
REQ-005 Parameter STABLE_TICKS SHALL default to 16 and set the number of consecutive disagreeing ticks needed to accept a new level (valid range 1..255).
REQ-006 Port clk SHALL be an input, 1 bit wide, and serve as the system clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n SHALL be an input, 1 bit wide, and act as the asynchronous active-low reset.
REQ-008 Port d SHALL be an input, CHANNELS bits wide, and carry raw asynchronous button or switch levels.
REQ-009 Port q SHALL be an output, CHANNELS bits wide, and carry the registered debounced levels.
REQ-010 Port rise SHALL be an output, CHANNELS bits wide, and pulse for one clk when q[i] goes 0->1.
REQ-011 Port fall SHALL be an output, CHANNELS bits wide, and pulse for one clk when q[i] goes 1->0.
REQ-012 Port tick SHALL be an output, 1 bit wide, and pulse for one clk on each sample tick.

Function
REQ-013 The shared divider SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly the clk cycle in which the count equals TICK_DIV-1.
REQ-014 With TICK_DIV=1, tick SHALL be held high continuously after reset release.
REQ-015 Each d[i] SHALL pass through a SYNC_STAGES-deep flip-flop chain; the output of the last stage is s[i].
REQ-016 Each channel SHALL own a stable counter cnt[i] of width ceil(log2(STABLE_TICKS+1)) bits.
REQ-017 In any clk cycle where s[i]==q[i], cnt[i] SHALL clear to 0, with or without tick.
REQ-018 On a tick with s[i]!=q[i] and cnt[i]<STABLE_TICKS-1, cnt[i] SHALL increment by 1.
REQ-019 On a tick with s[i]!=q[i] and cnt[i]==STABLE_TICKS-1, q[i] SHALL load s[i] and cnt[i] SHALL clear to 0 on the same edge.
REQ-020 A level change on d[i] SHALL reach q[i] no earlier than SYNC_STAGES+(STABLE_TICKS-1)*TICK_DIV+1 clk cycles after it changes.
REQ-021 A level change on d[i] SHALL reach q[i] no later than SYNC_STAGES+STABLE_TICKS*TICK_DIV clk cycles after it changes.
REQ-022 Any glitch that returns s[i] to q[i] before the acceptance tick SHALL leave q[i] unchanged and restart cnt[i] from 0.
REQ-023 rise[i] and fall[i] SHALL be registered and asserted on the same edge that updates q[i]; they SHALL never both be high.
REQ-024 Channels SHALL be fully independent; simultaneous acceptance on several channels in one tick SHALL update all of them on that edge.
REQ-025 cnt[i] SHALL never exceed STABLE_TICKS-1, and the divider SHALL never exceed TICK_DIV-1.

Reset
REQ-026 While rst_n=0, q, rise, fall, tick, the synchroniser chains, every cnt[i] and the divider SHALL all be 0 immediately, without waiting for clk.
REQ-027 Asserting rst_n mid-count SHALL abort all pending acceptances; after release, each channel SHALL restart from cnt=0, q=0.
REQ-028 The first tick after reset release SHALL occur TICK_DIV clk cycles after the first rising clk edge with rst_n=1.

Configuration
REQ-029 With macro DEBOUNCE_EDGE_EN defined, the rise and fall edge-pulse logic SHALL be compiled in as specified in REQ-010, REQ-011 and REQ-023.
REQ-030 With DEBOUNCE_EDGE_EN undefined, the rise and fall ports SHALL still exist but be tied to constant 0, no edge registers SHALL be built, and all other behaviour SHALL be identical.

Verification (CHANNELS=4, SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3, DEBOUNCE_EDGE_EN defined unless noted)
REQ-031 Reset check: drive rst_n=0 asynchronously mid-cycle with d=4'hF -> q, rise, fall and tick read 0 within the same timestep; after release, tick first pulses at cycle 4.
REQ-032 Clean press: step d[0] 0->1 and hold -> q[0] rises between cycle 11 and cycle 14 after the step, rise[0] is high for exactly 1 cycle on that edge, and q[3:1] stay 0.
REQ-033 Bounce rejection: toggle d[1] every 3 clk cycles for 40 cycles, then hold it at 0 -> q[1] stays 0 and rise[1]=fall[1]=0 throughout.
REQ-034 Release and parallel activity: with q=4'hF, drop d[3:2] to 0 in the same cycle -> q becomes 4'h3 on a single edge, and fall[3:2]=2'b11 for 1 cycle.
REQ-035 Reset mid-count: assert rst_n for 1 cycle after 2 disagreeing ticks on d[0]=1 -> q[0] requires a full 3 fresh ticks after release.
REQ-036 DEBOUNCE_EDGE_EN undefined: rerun REQ-032 -> q behaviour is identical and rise=fall=4'h0 for the whole run.
